muldiv_sequencer: RTL and testbench

Iterative signed multiply/divide engine with a start/done handshake. It feeds the HI/LO registers of the multicycle CPU. The control unit pulses start with an opcode, then stalls in a wait state until done, and then asserts the HI/LO write strobe. The block contains the FSM, the iteration counter and the shift/add/subtract datapath, so MULT and DIV share one adder.

---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed multiply/divide engine for the HI/LO registers
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int AW = WIDTH + 2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 op_q;
    logic                 sgn_lo_q;
    logic                 sgn_hi_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div0_q;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [AW-1:0]        add_x;
    logic [AW-1:0]        add_y;
    logic [AW-1:0]        add_r;
    logic                 add_sub;
    logic [2*WIDTH-1:0]   fix_prod;
    logic [WIDTH-1:0]     fix_quo;
    logic [WIDTH-1:0]     fix_rem;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // One adder serves both algorithms: add for shift-add MULT, subtract for the DIV trial.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        if (op_q) begin
            add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            add_y   = {2'b00, opnd_q};
            add_sub = 1'b1;
        end else begin
            add_x = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
            add_y = acc_q[0] ? {2'b00, opnd_q} : '0;
        end
    end

    assign add_r = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);

    // DIV keeps the remainder in the upper half and shifts quotient bits into the lower half.
    always_comb begin
        acc_d = acc_q;
        if (op_q) begin
            if (add_r[AW-1]) begin
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {add_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_d = {add_r[WIDTH:0], acc_q[WIDTH-1:1]};
        end
    end

    assign fix_prod = sgn_lo_q ? -acc_q : acc_q;
    assign fix_quo  = sgn_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign fix_rem  = sgn_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            sgn_lo_q <= 1'b0;
            sgn_hi_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (op && (b == '0)) begin
                            div0_q <= 1'b1;
                        end else begin
                            op_q     <= op;
                            sgn_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            sgn_hi_q <= a[WIDTH-1];
                            acc_q    <= {{WIDTH{1'b0}}, op ? abs_a : abs_b};
                            opnd_q   <= op ? abs_b : abs_a;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!abort) begin
                        if (op_q) begin
                            hi_q <= fix_rem;
                            lo_q <= fix_quo;
                        end else begin
                            hi_q <= fix_prod[2*WIDTH-1:WIDTH];
                            lo_q <= fix_prod[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int total = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_result(input logic opx, input logic [31:0] ax, input logic [31:0] bx);
        longint sa, sb, p, q, r;
        sa = longint'(signed'(ax));
        sb = longint'(signed'(bx));
        if (!opx) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: an accepted request produces its result 33 edges later.
    logic        m_busy = 0, m_done = 0, m_div0 = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_pend = 0;
    int          m_left = 0;

    always @(posedge clk) begin
        m_done = 1'b0;
        m_div0 = 1'b0;
        if (!reset) begin
            m_busy = 0; m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0; m_busy = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_pend[63:32]; m_lo = m_pend[31:0];
                    m_done = 1; m_busy = 0;
                end
            end
        end else if (start && !abort) begin
            if (op && b == 0) m_div0 = 1;
            else begin
                m_pend = ref_result(op, a, b);
                m_left = 33;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("div0", {63'd0, div0}, {63'd0, m_div0});
            chk("hi", {32'd0, hi}, {32'd0, m_hi});
            chk("lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    task automatic launch(input logic opx, input logic [31:0] ax, input logic [31:0] bx);
        start = 1'b1; op = opx; a = ax; b = bx;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic watch_no_done(input int n, input string name);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("ref_pin_div", ref_result(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mult_busy_early", {63'd0, busy}, 64'd1);
        wait_done(lat);
        chk("mult_lat", 64'(lat), 64'd33);
        chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        chk("div_neg_lat", 64'(lat), 64'd33);
        chk("div_neg_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        launch(1'b1, 32'd100, 32'd7);
        wait_done(lat);
        chk("div_b2b_lat", 64'(lat), 64'd33);
        chk("div_b2b_res", {hi, lo}, {32'd2, 32'd14});

        launch(1'b1, 32'd59, 32'd6);
        wait_done(lat);
        chk("div_prior", {hi, lo}, {32'd5, 32'd9});
        @(negedge clk);
        launch(1'b1, 32'd1234, 32'd0);
        chk("div0_pulse", {63'd0, div0}, 64'd1);
        chk("div0_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("div0_once", {63'd0, div0}, 64'd0);
        watch_no_done(36, "div0_no_done");
        chk("div0_keep", {hi, lo}, {32'd5, 32'd9});

        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        chk("mult_min", {hi, lo}, 64'h4000_0000_0000_0000);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("div_wrap", {hi, lo}, 64'h0000_0000_8000_0000);

        @(negedge clk);
        launch(1'b1, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'd55; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        watch_no_done(30, "abort_no_done");
        chk("abort_keep", {hi, lo}, 64'h0000_0000_8000_0000);
        start = 1'b1; abort = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", {63'd0, busy}, 64'd0);
        launch(1'b0, 32'd3, 32'd4);
        wait_done(lat);
        chk("mult_after_abort", {hi, lo}, 64'd12);

        @(negedge clk);
        launch(1'b0, 32'd11, 32'd13);
        repeat (14) @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("mid_rst_res", {hi, lo}, 64'd0);
        chk("mid_rst_flags", {61'd0, busy, done, div0}, 64'd0);
        reset = 1'b1; start = 1'b0;
        watch_no_done(40, "mid_rst_no_done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
